// File: rtl/icache_if.sv
// Datapath-fetch and memory-read signals of the direct-mapped instruction cache.
// The slave modport is the cache's view of this bundle. The master modport is the view of the datapath and memory side.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    modport slave (
        input  imemREN, imemaddr, iflush, iload, iwait,
        output ihit, imemload, iREN, iaddr
    );
    modport master (
        output imemREN, imemaddr, iflush, iload, iwait,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line, read-only instruction cache: hits return in 0 cycles, and a miss fetches one word.
// Defining ICACHE_PERF_EN adds the saturating hit_count and miss_count outputs.
module icache #(
    parameter int ENTRIES = 16
) (
    input  logic CLK,
    input  logic RST,
    icache_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FETCH} state_e;

    state_e               state_q, state_d;
    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [29:0]          maddr_q, maddr_d;
    logic [TW-1:0]        tag_q  [ENTRIES];
    logic [31:0]          data_q [ENTRIES];

    logic [IW-1:0] req_idx, fill_idx;
    logic [TW-1:0] req_tag;
    logic          idle_hit, fill, hit, miss;
    logic [31:0]   load;

    assign req_idx  = bus.imemaddr[IW+1:2];
    assign req_tag  = bus.imemaddr[31:IW+2];
    assign fill_idx = maddr_q[IW-1:0];
    assign idle_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill     = (state_q == FETCH) && !bus.iwait;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        maddr_d  = maddr_q;
        hit      = 1'b0;
        miss     = 1'b0;
        load     = 32'h0;
        bus.iREN  = 1'b0;
        bus.iaddr = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.imemREN) begin
                    if (idle_hit && !bus.iflush) begin
                        hit  = 1'b1;
                        load = data_q[req_idx];
                    end else begin
                        miss    = 1'b1;
                        maddr_d = bus.imemaddr[31:2];
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                bus.iREN  = 1'b1;
                bus.iaddr = {maddr_q, 2'b00};
                if (!bus.iwait) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                    // Forward the returning word when the datapath still wants this exact address.
                    if (bus.imemREN && (bus.imemaddr[31:2] == maddr_q) && !bus.iflush) begin
                        hit  = 1'b1;
                        load = bus.iload;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides any fill that lands on the same edge.
        if (bus.iflush) valid_d = '0;
    end

    assign bus.ihit     = hit;
    assign bus.imemload = load;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            valid_q <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            maddr_q <= maddr_d;
        end
    end

    // The tag and data arrays have no reset, because the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (!RST && fill) begin
            tag_q[fill_idx]  <= maddr_q[29:IW];
            data_q[fill_idx] <= bus.iload;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && hit_count_q != 32'hFFFF_FFFF)   hit_count_d  = hit_count_q + 32'd1;
        if (miss && miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_icache.sv
// Bench for icache: a cycle driver pushes the expected response of each cycle, taken from a word-address reference model.
// A negedge monitor pops each expected response and compares it with the DUT outputs.
module tb_icache;
    localparam int ENTRIES = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    icache_if bus ();

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache #(.ENTRIES(ENTRIES)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        logic        hit;
        logic [31:0] load;
        logic        ren;
        logic [31:0] addr;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: each line maps a word address to its data, and the line slot is (word address mod ENTRIES).
    bit          m_fetch = 0;
    int unsigned m_pend  = 0;
    int unsigned line_wa [int];
    int unsigned line_dat[int];
    int unsigned m_hits = 0, m_miss = 0;

    function automatic int unsigned mem_word(input int unsigned wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit ren, input int unsigned addr,
                       input bit flush, input bit wt);
        exp_t        e;
        bit          cached, hit;
        int unsigned wa, slot, ld;
        wa   = addr >> 2;
        slot = wa % ENTRIES;
        ld   = m_fetch ? mem_word(m_pend) : $urandom;
        RST          = rst;
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.iflush   = flush;
        bus.iwait    = wt;
        bus.iload    = ld;
        cached = line_wa.exists(slot) && line_wa[slot] == wa;
        hit    = !rst && !flush && ren &&
                 ((!m_fetch && cached) || (m_fetch && !wt && wa == m_pend));
        e.hit  = hit;
        e.load = hit ? (m_fetch ? ld : line_dat[slot]) : 32'h0;
        e.ren  = m_fetch;
        e.addr = m_fetch ? (m_pend << 2) : 32'h0;
        if (!rst) expq.push_back(e);
        @(posedge CLK);
        if (rst) begin
            m_fetch = 0;
            m_pend  = 0;
            line_wa.delete();
            line_dat.delete();
        end else begin
            if (hit) m_hits++;
            if (m_fetch) begin
                if (!wt) begin
                    if (!flush) begin
                        line_wa [m_pend % ENTRIES] = m_pend;
                        line_dat[m_pend % ENTRIES] = ld;
                    end
                    m_fetch = 0;
                end
            end else if (ren && !hit) begin
                m_fetch = 1;
                m_pend  = wa;
                m_miss++;
            end
            if (flush) begin
                line_wa.delete();
                line_dat.delete();
            end
        end
        #1;
    endtask

    // One access: it waits nw busy cycles, then drops iwait.
    task automatic access(input int unsigned addr, input int nw);
        cyc(0, 1, addr, 0, 1);
        for (int i = 0; i < nw; i++) cyc(0, 1, addr, 0, 1);
        cyc(0, 1, addr, 0, 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ihit",     {31'h0, bus.ihit}, {31'h0, e.hit});
            chk("imemload", bus.imemload,      e.load);
            chk("iREN",     {31'h0, bus.iREN}, {31'h0, e.ren});
            chk("iaddr",    bus.iaddr,         e.addr);
        end
    end

    initial begin
        int unsigned hits0, miss0;
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);                  // reset-state outputs

        // Cold miss with two busy cycles, bypass on fill, then 0-cycle hit
        access(32'h40, 2);
        cyc(0, 1, 32'h40, 0, 1);

        // Conflict on the same index
        access(32'h0, 1);
        access(32'h40, 0);
        access(32'h0, 0);

        // Squash: the fill completes but ihit stays low, then 0x100 hits and 0x200 misses
        cyc(0, 1, 32'h100, 0, 1);
        cyc(0, 1, 32'h200, 0, 1);
        cyc(0, 1, 32'h200, 0, 0);
        cyc(0, 1, 32'h100, 0, 1);
        access(32'h200, 0);

        // Flush warm lines, then a flush on the fill edge
        access(32'h0, 0);
        access(32'h4, 0);
        cyc(0, 0, 0, 1, 1);
        access(32'h0, 0);
        access(32'h4, 0);
        cyc(0, 1, 32'h8, 0, 1);
        cyc(0, 1, 32'h8, 0, 1);
        cyc(0, 1, 32'h8, 1, 0);
        access(32'h8, 0);

        // Reset in the middle of a fetch
        cyc(0, 1, 32'h300, 0, 1);
        cyc(0, 1, 32'h300, 0, 1);
        cyc(1, 0, 32'h300, 0, 1);
        cyc(0, 0, 32'h300, 0, 1);
        access(32'h300, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit          rst, ren, fl, wt;
            int unsigned a;
            rst = ($urandom_range(0, 99) == 0);
            ren = !rst && ($urandom_range(0, 3) != 0);
            fl  = !rst && ($urandom_range(0, 31) == 0);
            wt  = rst || ($urandom_range(0, 9) < 4);
            a   = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) != 0) a = a | 32'h8000_0000;
            cyc(rst, ren, a, fl, wt);
        end

`ifdef ICACHE_PERF_EN
        // Counter check: one miss plus three hits, where the bypass hit counts as a hit
        cyc(1, 0, 0, 0, 1);
        hits0 = m_hits;
        miss0 = m_miss;
        cyc(0, 1, 32'h500, 0, 1);
        cyc(0, 1, 32'h500, 0, 0);
        cyc(0, 1, 32'h500, 0, 1);
        cyc(0, 1, 32'h500, 0, 1);
        cyc(0, 1, 32'h500, 0, 1);
        chk("miss_count", miss_count, m_miss - miss0);
        chk("hit_count",  hit_count,  m_hits - hits0);
        chk("miss_count_req", miss_count, 32'd1);
        chk("hit_count_req",  hit_count,  32'd4);
`else
        hits0 = m_hits;
        miss0 = m_miss;
`endif

        cyc(0, 0, 0, 0, 1);
        @(negedge CLK);
        #1;
        chk("queue_drained", expq.size(), 32'd0);
        $display("model hits %0d misses %0d", hits0, miss0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: ENTRIES, default 16, number of one-word direct-mapped lines; power of two, >= 2.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath fetch byte address; bits [1:0] ignored.
REQ-006 iflush  input  1  invalidate all lines.
REQ-007 ihit  output  1  instruction valid on imemload this cycle.
REQ-008 imemload  output  32  instruction word to datapath.
REQ-009 iREN  output  1  read request to memory controller.
REQ-010 iaddr  output  32  word-aligned memory read address.
REQ-011 iload  input  32  memory read data, valid when iREN=1 and iwait=0.
REQ-012 iwait  input  1  memory busy; iload not yet valid.

Function
REQ-013 Address split SHALL be: index = imemaddr[2+log2(ENTRIES)-1:2], tag = imemaddr[31:2+log2(ENTRIES)].
REQ-014 Storage SHALL be per line: valid bit, tag, 32-bit data.
REQ-015 FSM states SHALL be IDLE and FETCH only.
REQ-016 IDLE hit (imemREN=1, valid[index]=1, tag match): ihit=1, imemload=line data, same cycle (0-cycle latency); state stays IDLE.
REQ-017 IDLE miss (imemREN=1, no hit): ihit=0; miss word address latched into maddr; next state FETCH.
REQ-018 IDLE with imemREN=0: ihit=0, iREN=0, no state change.
REQ-019 FETCH: iREN=1, iaddr={maddr[31:2],2'b00}, held stable until iwait=0.
REQ-020 FETCH with iwait=0: line at maddr's index written (valid=1, tag, data=iload) on that edge; next state IDLE.
REQ-021 Fill-cycle bypass: in FETCH with iwait=0, imemREN=1 and imemaddr[31:2]==maddr[31:2], ihit=1 and imemload=iload that cycle.
REQ-022 Address change during FETCH (branch/squash): fill SHALL complete into maddr's line; ihit SHALL stay 0 unless REQ-021 matches; new address handled as IDLE lookup afterwards.
REQ-023 imemREN dropped during FETCH: fetch SHALL still complete and fill; ihit=0.
REQ-024 Outside FETCH: iREN=0, iaddr=32'h0.
REQ-025 ihit=0 implies imemload=32'h0.
REQ-026 iflush=1: all valid bits cleared on the edge; no hit reported that cycle; FETCH in progress continues, but its fill SHALL NOT set valid if iflush=1 on the fill edge (flush wins).
REQ-027 Eviction: a fill SHALL overwrite the indexed line unconditionally; no write-back (read-only cache).

Reset
REQ-028 RST=1 on an edge: state IDLE, all valid bits 0, maddr 0; tag/data arrays need not be cleared.
REQ-029 Outputs while in reset state: ihit=0, imemload=32'h0, iREN=0, iaddr=32'h0.
REQ-030 RST asserted mid-FETCH SHALL abort the fetch; no line written; iREN=0 the following cycle.

Configuration
REQ-031 Macro ICACHE_PERF_EN: when defined, outputs hit_count[31:0] and miss_count[31:0] exist; hit_count increments per REQ-016/REQ-021 hit cycle, miss_count per IDLE->FETCH transition; both saturate at 32'hFFFFFFFF, reset to 0 on RST.
REQ-032 ICACHE_PERF_EN undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Cold miss: RST, then imemREN=1, imemaddr=0x00000040, iwait=1 for 2 cycles then 0 with iload=0x8C010004 -> iREN=1 with iaddr=0x40 for 3 cycles, ihit=1/imemload=0x8C010004 on the fill cycle; repeat access -> hit in 0 cycles.
REQ-034 Conflict: fill 0x00000000, then fetch 0x00000040 (ENTRIES=16, same index) -> miss, line replaced; re-fetch 0x00000000 -> miss again.
REQ-035 Squash: miss on 0x100, change imemaddr to 0x200 before iwait drops -> ihit=0 at fill; later 0x100 hits, 0x200 misses.
REQ-036 Flush: warm lines 0x0/0x4, pulse iflush -> both subsequently miss; iflush on fill edge -> line not valid.
REQ-037 Reset mid-FETCH: RST during iwait=1 -> iREN=0 next cycle; prior address misses afterwards.
REQ-038 ICACHE_PERF_EN: 1 miss + 3 hits -> miss_count=1, hit_count=4 (bypass counts); without macro compiles with no counter ports.
